// File: rtl/exe_stage_mc.sv
// Handshaked MIPS execute stage: registered EX/MEM result with valid/ready on both
// sides, single-cycle ALU ops and an iterative shift-add multiply that stalls upstream.
module exe_stage_mc #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5,
    parameter int SH_W     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    pc,
    input  logic [WIDTH-1:0]    imm,
    input  logic [REG_ADDR-1:0] rd_idx,
    input  logic [REG_ADDR-1:0] rt_idx,
    input  logic [WIDTH-1:0]    dato_1,
    input  logic [WIDTH-1:0]    dato_2,
    input  logic                alu_src,
    input  logic                reg_dst,
    input  logic [3:0]          alu_control,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    alu_result,
    output logic                zero_flag,
    output logic                overflow,
    output logic [WIDTH-1:0]    branch_target,
    output logic [REG_ADDR-1:0] dest_reg,
    output logic                busy
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_ADDU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

    state_t                state_q, state_d;
    logic [SH_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]      mplier_q, mplier_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]      bt_pend_q, bt_pend_d;
    logic [REG_ADDR-1:0]   dest_pend_q, dest_pend_d;

    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic                  zero_q, zero_d;
    logic                  ovf_q, ovf_d;
    logic [WIDTH-1:0]      bt_q, bt_d;
    logic [REG_ADDR-1:0]   dest_q, dest_d;

    logic [WIDTH-1:0]      op_b, sum, diff, alu_res, bt_in, mul_add, acc_sum;
    logic [REG_ADDR-1:0]   dest_in;
    logic                  alu_ovf, accept, consume;

    assign in_ready = (state_q == S_IDLE) && !reset && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    assign op_b    = alu_src ? imm : dato_2;
    assign sum     = dato_1 + op_b;
    assign diff    = dato_1 - op_b;
    assign bt_in   = pc + (imm << 2);
    assign dest_in = reg_dst ? rd_idx : rt_idx;

    // One multiplier bit per cycle, LSB first; the multiplicand walks left.
    assign mul_add = mplier_q[0] ? mcand_q : '0;
    assign acc_sum = acc_q + mul_add;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_control)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (dato_1[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != dato_1[WIDTH-1]);
            end
            OP_AND:  alu_res = dato_1 & op_b;
            OP_OR:   alu_res = dato_1 | op_b;
            OP_NOR:  alu_res = ~(dato_1 | op_b);
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (dato_1[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != dato_1[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(dato_1) < $signed(op_b))};
            OP_SLL:  alu_res = dato_1 << op_b[SH_W-1:0];
            OP_SRL:  alu_res = dato_1 >> op_b[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        bt_pend_d   = bt_pend_q;
        dest_pend_d = dest_pend_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        bt_d        = bt_q;
        dest_d      = dest_q;

        case (state_q)
            S_IDLE: begin
                if (accept && alu_control == OP_MUL) begin
                    // Old result, if any, is being consumed on this same edge.
                    state_d     = S_MUL;
                    cnt_d       = '0;
                    mcand_d     = dato_1;
                    mplier_d    = op_b;
                    acc_d       = '0;
                    bt_pend_d   = bt_in;
                    dest_pend_d = dest_in;
                    out_valid_d = 1'b0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    res_d       = alu_res;
                    zero_d      = (alu_res == '0);
                    ovf_d       = alu_ovf;
                    bt_d        = bt_in;
                    dest_d      = dest_in;
                end else if (consume) begin
                    out_valid_d = 1'b0;
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SH_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    res_d       = acc_sum;
                    zero_d      = (acc_sum == '0);
                    ovf_d       = 1'b0;
                    bt_d        = bt_pend_q;
                    dest_d      = dest_pend_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            bt_pend_q   <= '0;
            dest_pend_q <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            bt_q        <= '0;
            dest_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            bt_pend_q   <= bt_pend_d;
            dest_pend_q <= dest_pend_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            bt_q        <= bt_d;
            dest_q      <= dest_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_result    = res_q;
    assign zero_flag     = zero_q;
    assign overflow      = ovf_q;
    assign branch_target = bt_q;
    assign dest_reg      = dest_q;
    assign busy          = (state_q == S_MUL);

endmodule

// File: tb/tb_exe_stage_mc.sv
// Randomised and directed bench for exe_stage_mc against an arithmetic reference model.
module tb_exe_stage_mc;
    localparam int W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] pc = '0, imm = '0, dato_1 = '0, dato_2 = '0;
    logic [4:0]   rd_idx = '0, rt_idx = '0;
    logic         alu_src = 1'b0, reg_dst = 1'b0;
    logic [3:0]   alu_control = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] alu_result, branch_target;
    logic         zero_flag, overflow, busy;
    logic [4:0]   dest_reg;

    int total = 0;
    int bad = 0;

    exe_stage_mc #(.WIDTH(W), .REG_ADDR(5), .SH_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .imm(imm), .rd_idx(rd_idx), .rt_idx(rt_idx),
        .dato_1(dato_1), .dato_2(dato_2), .alu_src(alu_src), .reg_dst(reg_dst),
        .alu_control(alu_control), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero_flag(zero_flag), .overflow(overflow),
        .branch_target(branch_target), .dest_reg(dest_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the arithmetic definition of each operation.
    function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic o);
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        o = 1'b0;
        case (op)
            4'd0: begin s = sa + sb; r = W'(s); o = (s > MAXS) || (s < MINS); end
            4'd1: r = a & b;
            4'd2: r = a | b;
            4'd3: r = ~(a | b);
            4'd4: r = a + b;
            4'd5: begin s = sa - sb; r = W'(s); o = (s > MAXS) || (s < MINS); end
            4'd6: r = (sa < sb) ? 1 : 0;
            4'd7: r = a << b[4:0];
            4'd8: r = a >> b[4:0];
            4'd9: begin p = {32'b0, a} * {32'b0, b}; r = p[W-1:0]; end
            default: r = '0;
        endcase
    endfunction

    // Model state: what the stage should be showing after the latest edge.
    int           mul_left = 0;
    logic         m_ov = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_res = '0, m_bt = '0, p_res = '0, p_bt = '0;
    logic [4:0]   m_dest = '0, p_dest = '0;

    function automatic logic exp_ready();
        return (mul_left == 0) && !reset && (!m_ov || out_ready);
    endfunction

    always @(posedge clk) begin : model
        logic [W-1:0] b, r, bt;
        logic o, acc;
        logic [4:0] d;
        if (reset) begin
            mul_left = 0; m_ov = 0; m_res = '0; m_zero = 0; m_ovf = 0; m_bt = '0; m_dest = '0;
        end else begin
            acc = in_valid && exp_ready();
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    m_ov = 1; m_res = p_res; m_zero = (p_res == 0); m_ovf = 0;
                    m_bt = p_bt; m_dest = p_dest;
                end
            end else if (acc) begin
                b = alu_src ? imm : dato_2;
                ref_alu(alu_control, dato_1, b, r, o);
                bt = pc + imm * 4;
                d = reg_dst ? rd_idx : rt_idx;
                if (alu_control == 4'd9) begin
                    mul_left = W; p_res = r; p_bt = bt; p_dest = d; m_ov = 0;
                end else begin
                    m_ov = 1; m_res = r; m_zero = (r == 0); m_ovf = o; m_bt = bt; m_dest = d;
                end
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        lit("in_ready", W'(in_ready), W'(exp_ready()));
        lit("busy", W'(busy), W'(mul_left > 0));
        lit("out_valid", W'(out_valid), W'(m_ov));
        lit("alu_result", alu_result, m_res);
        lit("zero_flag", W'(zero_flag), W'(m_zero));
        lit("overflow", W'(overflow), W'(m_ovf));
        lit("branch_target", branch_target, m_bt);
        lit("dest_reg", W'(dest_reg), W'(m_dest));
    end

    task automatic set_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] d2,
                          input logic [W-1:0] im, input logic [W-1:0] p, input logic src,
                          input logic rdst, input logic [4:0] rd, input logic [4:0] rt);
        alu_control = op; dato_1 = a; dato_2 = d2; imm = im; pc = p;
        alu_src = src; reg_dst = rdst; rd_idx = rd; rt_idx = rt;
    endtask

    // Holds in_valid until the stage takes the op; returns at posedge+1 after acceptance.
    task automatic issue();
        int n = 0;
        logic got = 1'b0;
        in_valid = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!got) lit("issue_timeout", 0, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            5: return W'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nbusy;
        logic ok;
        repeat (2) @(posedge clk);
        #1;
        lit("rst_out_valid", W'(out_valid), 0);
        lit("rst_in_ready", W'(in_ready), 0);
        lit("rst_busy", W'(busy), 0);
        lit("rst_result", alu_result, 0);
        reset = 1'b0;

        // ADD overflow
        set_op(4'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 0, 0, 5'd1, 5'd2);
        issue();
        lit("add_valid", W'(out_valid), 1);
        lit("add_result", alu_result, 32'h8000_0000);
        lit("add_ovf", W'(overflow), 1);
        lit("add_zero", W'(zero_flag), 0);

        // SUB to zero, both destination selections
        set_op(4'd5, 32'd5, 32'd5, 32'h0, 32'h0, 0, 1, 5'd3, 5'd7);
        issue();
        lit("sub_result", alu_result, 0);
        lit("sub_zero", W'(zero_flag), 1);
        lit("sub_ovf", W'(overflow), 0);
        lit("sub_dest_rd", W'(dest_reg), 3);
        set_op(4'd5, 32'd5, 32'd5, 32'h0, 32'h0, 0, 0, 5'd3, 5'd7);
        issue();
        lit("sub_dest_rt", W'(dest_reg), 7);

        // SLT signed, branch target with negative immediate
        set_op(4'd6, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h100, 1, 0, 5'd0, 5'd4);
        issue();
        lit("slt_result", alu_result, 1);
        lit("slt_bt", branch_target, 32'h104);
        set_op(4'd4, 32'h10, 32'h0, 32'hFFFF_FFFF, 32'h100, 1, 0, 5'd0, 5'd4);
        issue();
        lit("bt_neg", branch_target, 32'hFC);
        lit("addu_wrap", alu_result, 32'hF);

        // MUL with a second op held during the multiply
        set_op(4'd9, 32'h1234, 32'h10, 32'h0, 32'h40, 0, 1, 5'd9, 5'd0);
        issue();
        set_op(4'd0, 32'd1, 32'd1, 32'h0, 32'h0, 0, 0, 5'd0, 5'd2);
        in_valid = 1'b1;
        nbusy = 0;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                lit("mul_valid", W'(out_valid), 1);
                lit("mul_result", alu_result, 32'h12340);
                lit("mul_bt", branch_target, 32'h40);
            end else if (busy) nbusy++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        lit("mul_busy_cycles", W'(nbusy), 32);
        lit("after_mul_add", alu_result, 2);

        // Back-pressure
        set_op(4'd0, 32'd10, 32'd20, 32'h0, 32'h0, 0, 0, 5'd0, 5'd1);
        issue();
        out_ready = 1'b0;
        set_op(4'd0, 32'd7, 32'd8, 32'h0, 32'h0, 0, 0, 5'd0, 5'd1);
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            lit("bp_in_ready", W'(in_ready), 0);
            lit("bp_valid", W'(out_valid), 1);
            lit("bp_hold", alu_result, 30);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        lit("bp_release_ready", W'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lit("bp_new_valid", W'(out_valid), 1);
        lit("bp_new_result", alu_result, 15);

        // Reset in the middle of a multiply
        set_op(4'd9, 32'd3, 32'd5, 32'h0, 32'h80, 0, 0, 5'd0, 5'd6);
        issue();
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        lit("mrst_valid", W'(out_valid), 0);
        lit("mrst_busy", W'(busy), 0);
        lit("mrst_result", alu_result, 0);
        lit("mrst_bt", branch_target, 0);
        lit("mrst_dest", W'(dest_reg), 0);
        reset = 1'b0;
        @(negedge clk);
        lit("mrst_in_ready", W'(in_ready), 1);
        @(posedge clk); #1;
        set_op(4'd0, 32'd2, 32'd3, 32'h0, 32'h0, 0, 0, 5'd0, 5'd1);
        issue();
        lit("post_rst_add", alu_result, 5);

        // Random traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_op(4'($urandom_range(0, 15)), pick(), pick(), pick(), $urandom, 1'($urandom),
                   1'($urandom), 5'($urandom), 5'($urandom));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
